// File: rtl/ff_bank.sv
// ---------------------------------------------------------------------------
// ff_bank -- bank of WIDTH configurable flip-flops (D / T / JK / SR).
//
// All state updates happen on the FALLING edge of clk. The reset is synchronous
// and active-high.
//
// Update priority on each falling edge:
//   rst > CLR > SET > (en ? mode operation : hold)
//
// Parameters
//   WIDTH          number of flip-flop bits (1..32)
//   SR_BOTH_POLICY action for SR-mode bits that see S=R=1:
//                  0 hold, 1 set, 2 reset, 3 toggle
//
// Ports
//   clk          in   clock; state updates on the falling edge
//   rst          in   synchronous reset, active-high
//   CLR          in   synchronous clear-all, active-high
//   SET          in   synchronous set-all, active-high
//   en           in   enable for the mode operation
//   mode         in   2'b00 D, 2'b01 T, 2'b10 JK, 2'b11 SR
//   a            in   D / T / J / S, one bit per flip-flop
//   b            in   K / R, one bit per flip-flop (unused in D and T modes)
//   clr_sts      in   clears the conflict status
//   Q            out  registered state
//   Qn           out  bitwise complement of Q
//   changed      out  1 for the cycle after an edge that altered Q
//   conflict     out  sticky: SR mode saw S=R=1 on some bit while enabled
//   conflict_cnt out  saturating count of conflicting edges
//
// Optional feature
//   FF_BANK_CONFLICT_CNT_EN  when defined, conflict_cnt is a saturating 8-bit
//                            counter; when undefined, conflict_cnt is tied to
//                            zero and no counter register exists.
// ---------------------------------------------------------------------------
module ff_bank #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned SR_BOTH_POLICY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CLR,
    input  logic             SET,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_sts,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             changed,
    output logic             conflict,
    output logic [7:0]       conflict_cnt
);

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    // JK: J alone sets, K alone resets, both toggle, neither holds.
    function automatic logic [WIDTH-1:0] jk_op(
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] j,
        input logic [WIDTH-1:0] k
    );
        jk_op = (j & ~q) | (~k & q);
    endfunction

    // SR: S alone sets, R alone resets, neither holds. Bits with S=R=1 start
    // from their held value and are then adjusted by SR_BOTH_POLICY, so every
    // bit always resolves to a defined 0 or 1.
    function automatic logic [WIDTH-1:0] sr_op(
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] s,
        input logic [WIDTH-1:0] r
    );
        logic [WIDTH-1:0] both;
        logic [WIDTH-1:0] res;
        both = s & r;
        res  = (q | (s & ~r)) & ~(r & ~s);
        case (SR_BOTH_POLICY)
            1:       res = res | both;
            2:       res = res & ~both;
            3:       res = res ^ both;
            default: res = res;
        endcase
        return res;
    endfunction

    logic [WIDTH-1:0] r_q;
    logic             r_changed;
    logic             r_conflict;

    logic [WIDTH-1:0] w_mode_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_conflict_hit;

    // Result of the selected mode operation, before CLR/SET/en priority.
    always_comb begin
        w_mode_q = r_q;
        case (mode)
            MODE_D:  w_mode_q = a;
            MODE_T:  w_mode_q = r_q ^ a;
            MODE_JK: w_mode_q = jk_op(r_q, a, b);
            MODE_SR: w_mode_q = sr_op(r_q, a, b);
            default: w_mode_q = r_q;
        endcase
    end

    // Next state with CLR/SET/en priority; rst is applied in the register.
    always_comb begin
        w_q_next = r_q;
        if (CLR) begin
            w_q_next = '0;
        end else if (SET) begin
            w_q_next = '1;
        end else if (en) begin
            w_q_next = w_mode_q;
        end
    end

    // A conflict needs the SR operation to actually be the one applied, so
    // CLR or SET on the same edge masks it. The count is per edge, not per bit.
    assign w_conflict_hit = en && (mode == MODE_SR) && !CLR && !SET && (|(a & b));

    always_ff @(negedge clk) begin
        if (rst) begin
            r_q       <= '0;
            r_changed <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_changed <= (w_q_next != r_q);
        end
    end

    // A new conflict on the same edge as clr_sts wins over the clear.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_conflict <= 1'b0;
        end else if (w_conflict_hit) begin
            r_conflict <= 1'b1;
        end else if (clr_sts) begin
            r_conflict <= 1'b0;
        end
    end

`ifdef FF_BANK_CONFLICT_CNT_EN
    logic [7:0] r_conflict_cnt;

    // Same-edge clear and conflict restarts the count at one.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_conflict_cnt <= 8'd0;
        end else if (w_conflict_hit) begin
            if (clr_sts) begin
                r_conflict_cnt <= 8'd1;
            end else if (r_conflict_cnt != CNT_MAX) begin
                r_conflict_cnt <= r_conflict_cnt + 8'd1;
            end
        end else if (clr_sts) begin
            r_conflict_cnt <= 8'd0;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    assign conflict_cnt = 8'd0;
`endif

    assign Q        = r_q;
    assign Qn       = ~r_q;
    assign changed  = r_changed;
    assign conflict = r_conflict;

endmodule

// File: tb/tb_ff_bank.sv
// ---------------------------------------------------------------------------
// tb_ff_bank -- directed self-checking bench for ff_bank (WIDTH=8,
// SR_BOTH_POLICY=3). Inputs change just after a rising edge, the DUT updates
// on the falling edge, and outputs are sampled on the following rising edge.
// ---------------------------------------------------------------------------
module tb_ff_bank;

`ifdef FF_BANK_CONFLICT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       CLR;
    logic       SET;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr_sts;
    logic [7:0] Q;
    logic [7:0] Qn;
    logic       changed;
    logic       conflict;
    logic [7:0] conflict_cnt;

    int checks;
    int failures;

    ff_bank #(
        .WIDTH         (8),
        .SR_BOTH_POLICY(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .CLR         (CLR),
        .SET         (SET),
        .en          (en),
        .mode        (mode),
        .a           (a),
        .b           (b),
        .clr_sts     (clr_sts),
        .Q           (Q),
        .Qn          (Qn),
        .changed     (changed),
        .conflict    (conflict),
        .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one set of inputs across one falling edge, return at the next
    // rising edge where outputs are stable.
    task automatic drive(input logic i_rst, input logic i_clr, input logic i_set,
                         input logic i_en, input logic [1:0] i_mode,
                         input logic [7:0] i_a, input logic [7:0] i_b,
                         input logic i_clr_sts);
        rst     = i_rst;
        CLR     = i_clr;
        SET     = i_set;
        en      = i_en;
        mode    = i_mode;
        a       = i_a;
        b       = i_b;
        clr_sts = i_clr_sts;
        @(negedge clk);
        @(posedge clk);
    endtask

    function automatic logic [7:0] exp_cnt(input logic [7:0] v);
        return CNT_EN ? v : 8'd0;
    endfunction

    task automatic test_reset();
        drive(1, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0);
        checks++; if (Q !== 8'h00) begin failures++; $display("FAIL reset_Q got=%h exp=%h", Q, 8'h00); end
        checks++; if (Qn !== 8'hFF) begin failures++; $display("FAIL reset_Qn got=%h exp=%h", Qn, 8'hFF); end
        checks++; if (changed !== 1'b0) begin failures++; $display("FAIL reset_changed got=%b exp=0", changed); end
        checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL reset_conflict got=%b exp=0", conflict); end
        checks++; if (conflict_cnt !== 8'h00) begin failures++; $display("FAIL reset_cnt got=%h exp=00", conflict_cnt); end
    endtask

    task automatic test_d_mode();
        drive(0, 0, 0, 1, 2'b00, 8'hA5, 8'h00, 0);
        checks++; if (Q !== 8'hA5) begin failures++; $display("FAIL d_Q got=%h exp=A5", Q); end
        checks++; if (Qn !== 8'h5A) begin failures++; $display("FAIL d_Qn got=%h exp=5A", Qn); end
        checks++; if (changed !== 1'b1) begin failures++; $display("FAIL d_changed got=%b exp=1", changed); end
        drive(0, 0, 0, 1, 2'b00, 8'hA5, 8'h00, 0);
        checks++; if (changed !== 1'b0) begin failures++; $display("FAIL d_repeat_changed got=%b exp=0", changed); end
        drive(0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0);
        checks++; if (Q !== 8'hA5) begin failures++; $display("FAIL en0_hold_Q got=%h exp=A5", Q); end
        checks++; if (changed !== 1'b0) begin failures++; $display("FAIL en0_changed got=%b exp=0", changed); end
    endtask

    task automatic test_t_jk();
        drive(0, 0, 0, 1, 2'b00, 8'h0F, 8'h00, 0);
        drive(0, 0, 0, 1, 2'b01, 8'hFF, 8'h00, 0);
        checks++; if (Q !== 8'hF0) begin failures++; $display("FAIL t_Q got=%h exp=F0", Q); end
        drive(0, 0, 0, 1, 2'b10, 8'h0F, 8'hF0, 0);
        checks++; if (Q !== 8'h0F) begin failures++; $display("FAIL jk_setreset_Q got=%h exp=0F", Q); end
        drive(0, 0, 0, 1, 2'b10, 8'hFF, 8'hFF, 0);
        checks++; if (Q !== 8'hF0) begin failures++; $display("FAIL jk_toggle_Q got=%h exp=F0", Q); end
        checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL jk_conflict got=%b exp=0", conflict); end
        drive(0, 0, 0, 1, 2'b10, 8'h0C, 8'hC0, 0);
        checks++; if (Q !== 8'h3C) begin failures++; $display("FAIL jk_mixed_Q got=%h exp=3C", Q); end
        checks++; if (changed !== 1'b1) begin failures++; $display("FAIL jk_changed got=%b exp=1", changed); end
    endtask

    task automatic test_sr_conflict();
        drive(0, 0, 0, 1, 2'b00, 8'h00, 8'h00, 0);
        drive(0, 0, 0, 0, 2'b11, 8'hFF, 8'hFF, 0);
        checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL sr_en0_conflict got=%b exp=0", conflict); end
        drive(0, 0, 0, 1, 2'b11, 8'h03, 8'h01, 0);
        checks++; if (Q !== 8'h03) begin failures++; $display("FAIL sr_toggle1_Q got=%h exp=03", Q); end
        checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL sr_conflict got=%b exp=1", conflict); end
        checks++; if (conflict_cnt !== exp_cnt(8'd1)) begin failures++; $display("FAIL sr_cnt got=%h exp=%h", conflict_cnt, exp_cnt(8'd1)); end
        drive(0, 0, 0, 1, 2'b11, 8'h03, 8'h01, 1);
        checks++; if (Q !== 8'h02) begin failures++; $display("FAIL sr_toggle2_Q got=%h exp=02", Q); end
        checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL sr_sameedge_conflict got=%b exp=1", conflict); end
        checks++; if (conflict_cnt !== exp_cnt(8'd1)) begin failures++; $display("FAIL sr_sameedge_cnt got=%h exp=%h", conflict_cnt, exp_cnt(8'd1)); end
        drive(0, 0, 0, 0, 2'b11, 8'h00, 8'h00, 1);
        checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL clrsts_conflict got=%b exp=0", conflict); end
        checks++; if (conflict_cnt !== 8'h00) begin failures++; $display("FAIL clrsts_cnt got=%h exp=00", conflict_cnt); end
        checks++; if (Q !== 8'h02) begin failures++; $display("FAIL clrsts_Q got=%h exp=02", Q); end
        drive(0, 0, 0, 1, 2'b11, 8'h80, 8'h02, 0);
        checks++; if (Q !== 8'h80) begin failures++; $display("FAIL sr_setreset_Q got=%h exp=80", Q); end
        checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL sr_noconf got=%b exp=0", conflict); end
    endtask

    task automatic test_clr_set();
        drive(0, 0, 0, 1, 2'b11, 8'h01, 8'h01, 0);
        checks++; if (Q !== 8'h81) begin failures++; $display("FAIL pre_clr_Q got=%h exp=81", Q); end
        drive(0, 1, 1, 1, 2'b00, 8'h55, 8'h00, 0);
        checks++; if (Q !== 8'h00) begin failures++; $display("FAIL clrset_Q got=%h exp=00", Q); end
        checks++; if (changed !== 1'b1) begin failures++; $display("FAIL clrset_changed got=%b exp=1", changed); end
        checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL clrset_conflict got=%b exp=1", conflict); end
        checks++; if (conflict_cnt !== exp_cnt(8'd1)) begin failures++; $display("FAIL clrset_cnt got=%h exp=%h", conflict_cnt, exp_cnt(8'd1)); end
        drive(0, 0, 1, 1, 2'b00, 8'h55, 8'h00, 0);
        checks++; if (Q !== 8'hFF) begin failures++; $display("FAIL set_Q got=%h exp=FF", Q); end
        checks++; if (Qn !== 8'h00) begin failures++; $display("FAIL set_Qn got=%h exp=00", Qn); end
        drive(0, 0, 1, 1, 2'b11, 8'hFF, 8'hFF, 0);
        checks++; if (Q !== 8'hFF) begin failures++; $display("FAIL set_sr_Q got=%h exp=FF", Q); end
        checks++; if (changed !== 1'b0) begin failures++; $display("FAIL set_sr_changed got=%b exp=0", changed); end
        checks++; if (conflict_cnt !== exp_cnt(8'd1)) begin failures++; $display("FAIL set_sr_cnt got=%h exp=%h", conflict_cnt, exp_cnt(8'd1)); end
    endtask

    task automatic test_saturation();
        drive(0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 1);
        checks++; if (conflict_cnt !== 8'h00) begin failures++; $display("FAIL sat_pre_cnt got=%h exp=00", conflict_cnt); end
        for (int i = 0; i < 300; i++) begin
            drive(0, 0, 0, 1, 2'b11, 8'h01, 8'h01, 0);
        end
        checks++; if (conflict_cnt !== exp_cnt(8'd255)) begin failures++; $display("FAIL sat_cnt got=%h exp=%h", conflict_cnt, exp_cnt(8'd255)); end
        checks++; if (conflict !== 1'b1) begin failures++; $display("FAIL sat_conflict got=%b exp=1", conflict); end
        // 300 toggles of bit0 starting from FF leave bit0 at 1.
        checks++; if (Q !== 8'hFF) begin failures++; $display("FAIL sat_Q got=%h exp=FF", Q); end
    endtask

    task automatic test_rst_priority();
        drive(1, 1, 1, 1, 2'b11, 8'hFF, 8'hFF, 0);
        checks++; if (Q !== 8'h00) begin failures++; $display("FAIL rstset_Q got=%h exp=00", Q); end
        checks++; if (Qn !== 8'hFF) begin failures++; $display("FAIL rstset_Qn got=%h exp=FF", Qn); end
        checks++; if (changed !== 1'b0) begin failures++; $display("FAIL rstset_changed got=%b exp=0", changed); end
        checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL rstset_conflict got=%b exp=0", conflict); end
        checks++; if (conflict_cnt !== 8'h00) begin failures++; $display("FAIL rstset_cnt got=%h exp=00", conflict_cnt); end
        drive(0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0);
        checks++; if (changed !== 1'b0) begin failures++; $display("FAIL post_rst_changed got=%b exp=0", changed); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; CLR = 1'b0; SET = 1'b0; en = 1'b0;
        mode = 2'b00; a = 8'h00; b = 8'h00; clr_sts = 1'b0;
        test_reset();
        test_d_mode();
        test_t_jk();
        test_sr_conflict();
        test_clr_set();
        test_saturation();
        test_rst_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
